// File: rtl/uart_rom_loader.sv
// UART boot loader: receives an A5|LEN|data frame and writes words into the instruction ROM.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_rom_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int ROM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    output logic        wen_o,
    output logic [31:0] w_addr_o,
    output logic [31:0] w_data_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_HDR, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERR
    } state_t;

    rx_state_t   rx_st;
    logic        rx_meta, rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  rx_byte;
    logic        byte_vld;
    logic        frame_err;

    // Receiver: sync, mid-bit sampling, one-cycle byte_vld / frame_err pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            rx_st     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= uart_rx_i;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= '0;
                        rx_st <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CW'(CPB - 1)) begin
                        cnt   <= '0;
                        rx_st <= RX_IDLE;
                        if (rx_s) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    state_t      st;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [15:0] len_in;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum8;
`endif

    assign len_in = {rx_byte, len[7:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            st         <= S_HDR;
            len        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            wen_o      <= 1'b0;
            w_addr_o   <= '0;
            w_data_o   <= '0;
            cpu_hold_o <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum8       <= '0;
`endif
        end else begin
            wen_o <= 1'b0;
            if (frame_err && st != S_DONE && st != S_ERR) begin
                st     <= S_ERR;
                err_o  <= 1'b1;
                busy_o <= 1'b0;
            end else begin
                case (st)
                    S_HDR: begin
                        if (byte_vld && rx_byte == 8'hA5) begin
                            st     <= S_LEN_LO;
                            busy_o <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            sum8   <= '0;
`endif
                        end
                    end
                    S_LEN_LO: begin
                        if (byte_vld) begin
                            len[7:0] <= rx_byte;
                            st       <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (byte_vld) begin
                            len[15:8] <= rx_byte;
                            word_idx  <= '0;
                            byte_idx  <= '0;
                            if (len_in == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                st <= S_CHK;
`else
                                st         <= S_DONE;
                                done_o     <= 1'b1;
                                cpu_hold_o <= 1'b0;
                                busy_o     <= 1'b0;
`endif
                            end else if (32'(len_in) > 32'(ROM_DEPTH)) begin
                                st     <= S_ERR;
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                            end else begin
                                st <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (byte_vld) begin
                            byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            sum8     <= sum8 + rx_byte;
`endif
                            if (byte_idx == 2'd3) begin
                                wen_o    <= 1'b1;
                                w_addr_o <= {14'd0, word_idx, 2'b00};
                                w_data_o <= {rx_byte, word_buf};
                                word_idx <= word_idx + 1'b1;
                            end else begin
                                word_buf <= {rx_byte, word_buf[23:8]};
                            end
                        end else if (wen_o && word_idx == len) begin
                            // Finish one cycle after the last write strobe.
`ifdef LOADER_CHECKSUM_EN
                            st <= S_CHK;
`else
                            st         <= S_DONE;
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                            busy_o     <= 1'b0;
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (byte_vld) begin
                            busy_o <= 1'b0;
                            if (rx_byte == sum8) begin
                                st         <= S_DONE;
                                done_o     <= 1'b1;
                                cpu_hold_o <= 1'b0;
                            end else begin
                                st    <= S_ERR;
                                err_o <= 1'b1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader at 8 clk/bit; covers LOADER_CHECKSUM_EN when defined.
module tb_uart_rom_loader;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        wen_o;
    logic [31:0] w_addr_o;
    logic [31:0] w_data_o;
    logic        cpu_hold_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    uart_rom_loader #(.CLK_FREQ(8_000_000), .BAUD(1_000_000), .ROM_DEPTH(4096)) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx_i),
        .wen_o(wen_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .cpu_hold_o(cpu_hold_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    int          cyc = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          last_wen_cyc = 0;
    int          done_cyc = 0;
    logic        done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wen_o) begin
            wa.push_back(w_addr_o);
            wd.push_back(w_data_o);
            last_wen_cyc <= cyc;
        end
        if (done_o && !done_q) done_cyc <= cyc;
        done_q <= done_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wa_at(input int i);
        return (i < wa.size()) ? wa[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wd_at(input int i);
        return (i < wd.size()) ? wd[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk) uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_i = stop;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_data_words();
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    endtask

    // Data bytes sum to 0x4C mod 256.
    task automatic send_frame();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_data_words();
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h4C);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"},  32'(wen_o), 32'd0);
        check({tag, "_addr"}, w_addr_o, 32'd0);
        check({tag, "_data"}, w_data_o, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"},  32'(err_o), 32'd0);
    endtask

    task automatic check_two_writes(input string tag, input int base);
        check({tag, "_nwr"},  32'(wa.size() - base), 32'd2);
        check({tag, "_a0"},   wa_at(base), 32'h0);
        check({tag, "_d0"},   wd_at(base), 32'h1234_5678);
        check({tag, "_a1"},   wa_at(base + 1), 32'h4);
        check({tag, "_d1"},   wd_at(base + 1), 32'hDEAD_BEEF);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: clean frame from reset
        check_reset_vals("s1_rst");
        base = wa.size();
        send_byte(8'hA5);
        check("s1_busy", 32'(busy_o), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_data_words();
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h4C);
`endif
        repeat (10) @(negedge clk);
        check_two_writes("s1", base);
        check("s1_done", 32'(done_o), 32'd1);
        check("s1_hold", 32'(cpu_hold_o), 32'd0);
        check("s1_err",  32'(err_o), 32'd0);
        check("s1_busy_end", 32'(busy_o), 32'd0);
`ifndef LOADER_CHECKSUM_EN
        check("s1_done_lat", 32'(done_cyc - last_wen_cyc), 32'd1);
`endif

        // 2: leading garbage ignored
        do_reset();
        base = wa.size();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        check("s2_busy_idle", 32'(busy_o), 32'd0);
        send_frame();
        repeat (10) @(negedge clk);
        check_two_writes("s2", base);
        check("s2_done", 32'(done_o), 32'd1);
        check("s2_err",  32'(err_o), 32'd0);

        // 3: length 0x1001 exceeds depth, later frame ignored
        do_reset();
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        repeat (4) @(negedge clk);
        check("s3_err",  32'(err_o), 32'd1);
        check("s3_hold", 32'(cpu_hold_o), 32'd1);
        check("s3_busy", 32'(busy_o), 32'd0);
        send_frame();
        repeat (10) @(negedge clk);
        check("s3_nwr",  32'(wa.size() - base), 32'd0);
        check("s3_done", 32'(done_o), 32'd0);
        check("s3_err2", 32'(err_o), 32'd1);

        // 4: stop bit low
        do_reset();
        send_byte(8'h55, 1'b0);
        check("s4_err",  32'(err_o), 32'd1);
        check("s4_busy", 32'(busy_o), 32'd0);
        check("s4_hold", 32'(cpu_hold_o), 32'd1);
        check("s4_done", 32'(done_o), 32'd0);

        // 5: reset after the 5th data byte, then reload
        do_reset();
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF);
        check("s5_partial_nwr", 32'(wa.size() - base), 32'd1);
        do_reset();
        check_reset_vals("s5_rst");
        base = wa.size();
        send_frame();
        repeat (10) @(negedge clk);
        check_two_writes("s5", base);
        check("s5_done", 32'(done_o), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum mismatch keeps written words but errors out
        do_reset();
        base = wa.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_data_words();
        send_byte(8'h5F);
        repeat (10) @(negedge clk);
        check_two_writes("s6", base);
        check("s6_err",  32'(err_o), 32'd1);
        check("s6_hold", 32'(cpu_hold_o), 32'd1);
        check("s6_done", 32'(done_o), 32'd0);

        // LEN=0 expects a zero checksum
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (4) @(negedge clk);
        check("s6_len0_done", 32'(done_o), 32'd1);
`else
        // LEN=0 finishes straight from the length field
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        repeat (4) @(negedge clk);
        check("s6_len0_done", 32'(done_o), 32'd1);
        check("s6_len0_hold", 32'(cpu_hold_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
